ps2_poly_note_mapper: RTL and testbench

Sequential, polyphonic successor to the combinational scan-code-to-note decoder. It consumes raw PS/2 set-2 scan-code bytes and decodes make, break (F0) and extended (E0) prefixes. It tracks which mapped keys are held and assigns each held note to one of VOICES tone-generator slots. It sits between the PS/2 receiver and the bank of tone generators, so several keys sound at once and each note stops on its own key release.

---
 rtl/piano_pkg.sv | 54 +++++
 rtl/ps2_key_decode.sv | 56 +++++
 rtl/ps2_poly_note_mapper.sv | 156 +++++++++++++++
 tb/tb_ps2_poly_note_mapper.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared constants for the PS/2 polyphonic note path: note codes, scan-code
// prefixes and the prefix decoder state encoding.
package piano_pkg;

    localparam logic [5:0] C3  = 6'd0;
    localparam logic [5:0] CS3 = 6'd1;
    localparam logic [5:0] D3  = 6'd2;
    localparam logic [5:0] DS3 = 6'd3;
    localparam logic [5:0] E3  = 6'd4;
    localparam logic [5:0] F3  = 6'd5;
    localparam logic [5:0] FS3 = 6'd6;
    localparam logic [5:0] G3  = 6'd7;
    localparam logic [5:0] GS3 = 6'd8;
    localparam logic [5:0] A3  = 6'd9;
    localparam logic [5:0] AS3 = 6'd10;
    localparam logic [5:0] B3  = 6'd11;
    localparam logic [5:0] C4  = 6'd12;
    localparam logic [5:0] CS4 = 6'd13;
    localparam logic [5:0] D4  = 6'd14;
    localparam logic [5:0] DS4 = 6'd15;
    localparam logic [5:0] E4  = 6'd16;
    localparam logic [5:0] F4  = 6'd17;
    localparam logic [5:0] FS4 = 6'd18;
    localparam logic [5:0] G4  = 6'd19;
    localparam logic [5:0] GS4 = 6'd20;
    localparam logic [5:0] A4  = 6'd21;
    localparam logic [5:0] AS4 = 6'd22;
    localparam logic [5:0] B4  = 6'd23;
    localparam logic [5:0] C5  = 6'd24;
    localparam logic [5:0] CS5 = 6'd25;
    localparam logic [5:0] D5  = 6'd26;
    localparam logic [5:0] DS5 = 6'd27;
    localparam logic [5:0] E5  = 6'd28;
    localparam logic [5:0] F5  = 6'd29;
    localparam logic [5:0] FS5 = 6'd30;
    localparam logic [5:0] G5  = 6'd31;
    localparam logic [5:0] GS5 = 6'd32;
    localparam logic [5:0] A5  = 6'd33;
    localparam logic [5:0] AS5 = 6'd34;
    localparam logic [5:0] B5  = 6'd35;
    localparam logic [5:0] STOP = 6'h3F;

    localparam logic [7:0] F0    = 8'hF0;
    localparam logic [7:0] E0    = 8'hE0;
    localparam logic [7:0] PANIC = 8'h76;

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } prefix_state_e;

endpackage

// File: rtl/ps2_key_decode.sv
// Set-2 scan byte to note lookup for the 36-key layout (two keyboard rows).
// Latency: combinational. Backpressure: none.
// Unmapped bytes return mapped=0 and note=STOP.
module ps2_key_decode
    import piano_pkg::*;
(
    input  logic [7:0] scan_code,
    output logic       mapped,
    output logic [5:0] note
);

    always_comb begin
        mapped = 1'b1;
        note   = STOP;
        unique case (scan_code)
            8'h15: note = C3;
            8'h1E: note = CS3;
            8'h1D: note = D3;
            8'h26: note = DS3;
            8'h24: note = E3;
            8'h2D: note = F3;
            8'h2E: note = FS3;
            8'h2C: note = G3;
            8'h36: note = GS3;
            8'h35: note = A3;
            8'h3D: note = AS3;
            8'h3C: note = B3;
            8'h43: note = C4;
            8'h46: note = CS4;
            8'h44: note = D4;
            8'h45: note = DS4;
            8'h4D: note = E4;
            8'h1A: note = F4;
            8'h1B: note = FS4;
            8'h22: note = G4;
            8'h23: note = GS4;
            8'h21: note = A4;
            8'h2B: note = AS4;
            8'h2A: note = B4;
            8'h32: note = C5;
            8'h34: note = CS5;
            8'h31: note = D5;
            8'h33: note = DS5;
            8'h3A: note = E5;
            8'h41: note = F5;
            8'h4B: note = FS5;
            8'h49: note = G5;
            8'h4C: note = GS5;
            8'h4A: note = A5;
            8'h52: note = AS5;
            8'h59: note = B5;
            default: mapped = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_poly_note_mapper.sv
// Decodes PS/2 make/break/extended bytes and assigns held notes to VOICES slots.
// Latency: one cycle from scan_code_ready to registered outputs. Backpressure: none, one byte per cycle.
// Full-slot policy: VOICE_STEAL_EN defined steals round-robin, otherwise the make code is dropped.
module ps2_poly_note_mapper
    import piano_pkg::*;
#(
    parameter int VOICES = 4,
    parameter int NOTE_W = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 scan_code,
    input  logic                       scan_code_ready,
    output logic [VOICES*NOTE_W-1:0]   voice_note,
    output logic [VOICES-1:0]          voice_active,
    output logic                       note_on,
    output logic                       note_off,
    output logic [((VOICES > 1) ? $clog2(VOICES) : 1)-1:0] event_voice,
    output logic                       overflow
);

    localparam int EV_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    prefix_state_e     state_q, state_d;
    logic [NOTE_W-1:0] notes_q [VOICES];
    logic [NOTE_W-1:0] notes_d [VOICES];
    logic [VOICES-1:0] active_d;
    logic              on_d, off_d, ovf_d;
    logic [EV_W-1:0]   ev_d;
`ifdef VOICE_STEAL_EN
    logic [EV_W-1:0]   steal_q, steal_d;
`endif

    logic              dec_mapped;
    logic [5:0]        dec_note;
    logic [NOTE_W-1:0] key_note;

    ps2_key_decode u_decode (
        .scan_code (scan_code),
        .mapped    (dec_mapped),
        .note      (dec_note)
    );

    assign key_note = NOTE_W'(dec_note);

    for (genvar g = 0; g < VOICES; g++) begin : g_out
        assign voice_note[g*NOTE_W +: NOTE_W] = notes_q[g];
    end

    // Held-note match and lowest-index free slot; loops run high to low so the lowest index wins.
    logic            hit_any, free_any;
    logic [EV_W-1:0] hit_idx, free_idx;

    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (voice_active[i] && notes_q[i] == key_note) begin
                hit_any = 1'b1;
                hit_idx = EV_W'(i);
            end
            if (!voice_active[i]) begin
                free_any = 1'b1;
                free_idx = EV_W'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        notes_d  = notes_q;
        active_d = voice_active;
        on_d     = 1'b0;
        off_d    = 1'b0;
        ovf_d    = 1'b0;
        ev_d     = event_voice;
`ifdef VOICE_STEAL_EN
        steal_d  = steal_q;
`endif
        if (scan_code_ready) begin
            unique case (state_q)
                IDLE: begin
                    if (scan_code == F0) begin
                        state_d = BRK;
                    end else if (scan_code == E0) begin
                        state_d = EXT;
                    end else if (scan_code == PANIC) begin
                        active_d = '0;
                        for (int i = 0; i < VOICES; i++) notes_d[i] = '1;
                        off_d = 1'b1;
                        ev_d  = '0;
                    end else if (dec_mapped && !hit_any) begin
                        if (free_any) begin
                            notes_d[free_idx]  = key_note;
                            active_d[free_idx] = 1'b1;
                            on_d = 1'b1;
                            ev_d = free_idx;
                        end else begin
`ifdef VOICE_STEAL_EN
                            notes_d[steal_q]  = key_note;
                            active_d[steal_q] = 1'b1;
                            on_d    = 1'b1;
                            ovf_d   = 1'b1;
                            ev_d    = steal_q;
                            steal_d = (steal_q == EV_W'(VOICES - 1)) ? '0 : steal_q + EV_W'(1);
`else
                            ovf_d = 1'b1;
`endif
                        end
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (dec_mapped && hit_any) begin
                        notes_d[hit_idx]  = '1;
                        active_d[hit_idx] = 1'b0;
                        off_d = 1'b1;
                        ev_d  = hit_idx;
                    end
                end
                EXT:     state_d = (scan_code == F0) ? EXT_BRK : IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            voice_active <= '0;
            note_on      <= 1'b0;
            note_off     <= 1'b0;
            overflow     <= 1'b0;
            event_voice  <= '0;
            for (int i = 0; i < VOICES; i++) notes_q[i] <= '1;
`ifdef VOICE_STEAL_EN
            steal_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            voice_active <= active_d;
            note_on      <= on_d;
            note_off     <= off_d;
            overflow     <= ovf_d;
            event_voice  <= ev_d;
            for (int i = 0; i < VOICES; i++) notes_q[i] <= notes_d[i];
`ifdef VOICE_STEAL_EN
            steal_q      <= steal_d;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_poly_note_mapper.sv
// Scoreboard bench for ps2_poly_note_mapper: a behavioural slot model queues the expected
// outputs for each strobe and a monitor compares them one cycle later.
module tb_ps2_poly_note_mapper;

    localparam int V = 4;
    localparam int NW = 6;

    localparam logic [7:0] KEYMAP [36] = '{
        8'h15, 8'h1E, 8'h1D, 8'h26, 8'h24, 8'h2D, 8'h2E, 8'h2C, 8'h36, 8'h35, 8'h3D, 8'h3C,
        8'h43, 8'h46, 8'h44, 8'h45, 8'h4D, 8'h1A, 8'h1B, 8'h22, 8'h23, 8'h21, 8'h2B, 8'h2A,
        8'h32, 8'h34, 8'h31, 8'h33, 8'h3A, 8'h41, 8'h4B, 8'h49, 8'h4C, 8'h4A, 8'h52, 8'h59
    };

    typedef struct packed {
        logic [V*NW-1:0] vn;
        logic [V-1:0]    va;
        logic            on;
        logic            off;
        logic            ovf;
        logic [1:0]      ev;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [7:0]      scan_code = 8'h00;
    logic            scan_code_ready = 1'b0;
    logic [V*NW-1:0] voice_note;
    logic [V-1:0]    voice_active;
    logic            note_on, note_off, overflow;
    logic [1:0]      event_voice;

    ps2_poly_note_mapper #(.VOICES(V), .NOTE_W(NW)) dut (
        .clk             (clk),
        .reset           (reset),
        .scan_code       (scan_code),
        .scan_code_ready (scan_code_ready),
        .voice_note      (voice_note),
        .voice_active    (voice_active),
        .note_on         (note_on),
        .note_off        (note_off),
        .event_voice     (event_voice),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int on_cnt  = 0;
    int off_cnt = 0;
    int ovf_cnt = 0;
    exp_t exp_q [$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Behavioural model
    int         m_state;
    logic [5:0] m_note [V];
    logic [V-1:0] m_act;
    logic [1:0] m_ev;
    int         m_steal;
    logic       m_on, m_off, m_ovf;

    function automatic int lookup(input logic [7:0] b);
        for (int i = 0; i < 36; i++) if (KEYMAP[i] == b) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_act = '0; m_ev = 2'd0; m_steal = 0;
        m_on = 1'b0; m_off = 1'b0; m_ovf = 1'b0;
        for (int i = 0; i < V; i++) m_note[i] = 6'h3F;
    endtask

    task automatic model_step(input logic [7:0] b);
        int n, held, fr;
        m_on = 1'b0; m_off = 1'b0; m_ovf = 1'b0;
        n = lookup(b);
        held = -1;
        fr = -1;
        for (int i = 0; i < V; i++) begin
            if (held < 0 && m_act[i] && n >= 0 && m_note[i] == 6'(n)) held = i;
            if (fr < 0 && !m_act[i]) fr = i;
        end
        case (m_state)
            0: begin
                if (b == 8'hF0) m_state = 1;
                else if (b == 8'hE0) m_state = 2;
                else if (b == 8'h76) begin
                    m_act = '0;
                    for (int i = 0; i < V; i++) m_note[i] = 6'h3F;
                    m_off = 1'b1; m_ev = 2'd0;
                end else if (n >= 0 && held < 0) begin
                    if (fr >= 0) begin
                        m_note[fr] = 6'(n); m_act[fr] = 1'b1; m_on = 1'b1; m_ev = 2'(fr);
                    end else begin
                        m_ovf = 1'b1;
`ifdef VOICE_STEAL_EN
                        m_note[m_steal] = 6'(n); m_on = 1'b1; m_ev = 2'(m_steal);
                        m_steal = (m_steal + 1) % V;
`endif
                    end
                end
            end
            1: begin
                m_state = 0;
                if (held >= 0) begin
                    m_note[held] = 6'h3F; m_act[held] = 1'b0; m_off = 1'b1; m_ev = 2'(held);
                end
            end
            2: m_state = (b == 8'hF0) ? 3 : 0;
            default: m_state = 0;
        endcase
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        for (int i = 0; i < V; i++) e.vn[i*NW +: NW] = m_note[i];
        e.va = m_act; e.on = m_on; e.off = m_off; e.ovf = m_ovf; e.ev = m_ev;
        return e;
    endfunction

    // Stimulus helpers; consecutive send calls give back-to-back strobes.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        scan_code = b;
        scan_code_ready = 1'b1;
        model_step(b);
        exp_q.push_back(snapshot());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            scan_code_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        scan_code_ready = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: pops one expectation per captured strobe, otherwise checks pulses are idle.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        on_cnt  += int'(note_on);
        off_cnt += int'(note_off);
        ovf_cnt += int'(overflow);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("voice_note", 32'(voice_note), 32'(e.vn));
            chk("voice_active", 32'(voice_active), 32'(e.va));
            chk("note_on", 32'(note_on), 32'(e.on));
            chk("note_off", 32'(note_off), 32'(e.off));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("event_voice", 32'(event_voice), 32'(e.ev));
        end else begin
            chk("idle_pulses", {29'd0, note_on, note_off, overflow}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_tests %0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int c_on, c_off, c_ovf;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_note", 32'(voice_note), 32'hFF_FFFF);
        chk("rst_active", 32'(voice_active), 32'd0);
        chk("rst_ev", 32'(event_voice), 32'd0);

        // First make code lands in slot 0
        send(8'h15); idle(2);
        chk("c3_slot0", 32'(voice_note[5:0]), 32'h00);
        chk("c3_active", 32'(voice_active), 32'b0001);

        // D3 to slot1, then break C3 frees slot0
        send(8'h1D); send(8'hF0); send(8'h15); idle(2);
        chk("d3_slot1", 32'(voice_note[11:6]), 32'h02);
        chk("brk_active", 32'(voice_active), 32'b0010);
        chk("brk_ev", 32'(event_voice), 32'd0);

        // Typematic repeat gives one note_on
        c_on = on_cnt;
        send(8'h15); send(8'h15); send(8'h15); idle(2);
        chk("typematic_on", 32'(on_cnt - c_on), 32'd1);
        chk("typematic_act", 32'(voice_active), 32'b0011);

        // Fill all slots, then one more make code
        send(8'h24); send(8'h2D); idle(1);
        c_on = on_cnt; c_ovf = ovf_cnt;
        send(8'h45); idle(2);
        chk("full_ovf", 32'(ovf_cnt - c_ovf), 32'd1);
        chk("full_active", 32'(voice_active), 32'b1111);
`ifdef VOICE_STEAL_EN
        chk("steal_slot0", 32'(voice_note[5:0]), 32'h0F);
        chk("steal_on", 32'(on_cnt - c_on), 32'd1);
`else
        chk("drop_slot0", 32'(voice_note[5:0]), 32'h00);
        chk("drop_on", 32'(on_cnt - c_on), 32'd0);
`endif

        // Extended break ignored, then panic
        send(8'hE0); send(8'hF0); send(8'h1D); idle(2);
        chk("extbrk_active", 32'(voice_active), 32'b1111);
        c_off = off_cnt;
        send(8'h76); idle(2);
        chk("panic_note", 32'(voice_note), 32'hFF_FFFF);
        chk("panic_active", 32'(voice_active), 32'd0);
        chk("panic_off", 32'(off_cnt - c_off), 32'd1);
        chk("panic_ev", 32'(event_voice), 32'd0);

        // Extended make and unmapped byte are ignored
        send(8'hE0); send(8'h15); send(8'h05); idle(2);
        chk("extmake_active", 32'(voice_active), 32'd0);

        // Reset discards a pending F0 prefix
        send(8'hF0); idle(1);
        do_reset();
        send(8'h15); idle(2);
        chk("rstpfx_slot0", 32'(voice_note[5:0]), 32'h00);
        chk("rstpfx_active", 32'(voice_active), 32'b0001);

        // Reset wins over a simultaneous strobe
        @(negedge clk);
        reset = 1'b1; scan_code = 8'h1D; scan_code_ready = 1'b1;
        model_reset();
        exp_q.push_back(snapshot());
        @(negedge clk);
        reset = 1'b0; scan_code_ready = 1'b0;
        idle(1);
        chk("rst_prio_active", 32'(voice_active), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 19);
            if (r < 3) b = 8'hF0;
            else if (r < 4) b = 8'hE0;
            else if (r < 5) b = 8'h76;
            else if (r < 6) b = 8'h05;
            else b = KEYMAP[$urandom_range(0, 6)];
            send(b);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        chk("drain", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
